// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch sequencer: opcodes, FSM states, IR fields.
package cpu_pkg;

  localparam int unsigned OP_W        = 3;
  localparam int unsigned IR_I_BIT    = 7;
  localparam int unsigned IR_OP_MSB   = 6;
  localparam int unsigned IR_OP_LSB   = 4;
  localparam int unsigned IR_ADDR_MSB = 3;
  localparam int unsigned IR_ADDR_LSB = 0;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD = 3'b001;
  localparam logic [OP_W-1:0] OP_LDA = 3'b010;
  localparam logic [OP_W-1:0] OP_STA = 3'b011;
  localparam logic [OP_W-1:0] OP_BUN = 3'b100;
  localparam logic [OP_W-1:0] OP_NOP = 3'b101;
  localparam logic [OP_W-1:0] OP_HLT = 3'b110;
  localparam logic [OP_W-1:0] OP_REG = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_IND,
    ST_OPND,
    ST_STORE,
    ST_ISSUE,
    ST_HALT
  } state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch/decode/operand-fetch/store sequencer driving the 16x8 RAM and issuing
// decoded instructions to the execution unit over a valid/ack handshake.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 4,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] ac_in,
  output logic              issue_valid,
  output logic [OP_W-1:0]   issue_op,
  output logic [DATA_W-1:0] issue_ir,
  output logic [DATA_W-1:0] issue_dr,
  input  logic              issue_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   ar_q, ar_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   dr_q, dr_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                issue_valid_q, issue_valid_d;
  logic                halted_q, halted_d;

  logic [OP_W-1:0]     op;
  logic                ind;
  logic [ADDR_W-1:0]   ir_addr;
  logic [ADDR_W-1:0]   rd_addr;
  state_e              end_st;

  assign op      = ir_q[IR_OP_MSB:IR_OP_LSB];
  assign ind     = ir_q[IR_I_BIT];
  assign ir_addr = ADDR_W'(ir_q[IR_ADDR_MSB:IR_ADDR_LSB]);
  assign rd_addr = ADDR_W'(mem_rdata[IR_ADDR_MSB:IR_ADDR_LSB]);
  // END is a decision, not a state: continue if run is still high.
  assign end_st  = run ? ST_T0 : ST_IDLE;

  // Next-state, register updates and registered-output decode.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ar_d          = ar_q;
    ir_d          = ir_q;
    dr_d          = dr_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_wdata_d   = '0;
    issue_valid_d = 1'b0;
    halted_d      = 1'b0;

    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0: begin
        ar_d    = pc_q;
        state_d = ST_T1;
      end
      ST_T1: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_T2;
      end
      ST_T2: begin
        ar_d = ir_addr;
        if (ind && (op <= OP_BUN)) begin
          state_d = ST_IND;
        end else begin
          case (op)
            OP_AND, OP_ADD, OP_LDA: state_d = ST_OPND;
            OP_STA:                 state_d = ST_STORE;
            OP_BUN: begin
              pc_d    = ir_addr;
              state_d = end_st;
            end
            OP_NOP:                 state_d = end_st;
            OP_HLT:                 state_d = ST_HALT;
            default: begin
              dr_d    = '0;
              state_d = ST_ISSUE;
            end
          endcase
        end
      end
      ST_IND: begin
        ar_d = rd_addr;
        case (op)
          OP_STA:  state_d = ST_STORE;
          OP_BUN: begin
            pc_d    = rd_addr;
            state_d = end_st;
          end
          default: state_d = ST_OPND;
        endcase
      end
      ST_OPND: begin
        dr_d    = mem_rdata;
        state_d = ST_ISSUE;
      end
      ST_STORE: state_d = end_st;
      ST_ISSUE: if (issue_ack) state_d = end_st;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_T1, ST_IND, ST_OPND: mem_read_d = 1'b1;
      ST_STORE: begin
        mem_write_d = 1'b1;
        mem_wdata_d = ac_in;
      end
      ST_ISSUE: issue_valid_d = 1'b1;
      ST_HALT:  halted_d      = 1'b1;
      default: ;
    endcase
  end

  // State, architectural registers and output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      ar_q          <= '0;
      ir_q          <= '0;
      dr_q          <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wdata_q   <= '0;
      issue_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ar_q          <= ar_d;
      ir_q          <= ir_d;
      dr_q          <= dr_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_wdata_q   <= mem_wdata_d;
      issue_valid_q <= issue_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = ar_q;
  assign mem_wdata   = mem_wdata_q;
  assign issue_valid = issue_valid_q;
  assign issue_op    = op;
  assign issue_ir    = ir_q;
  assign issue_dr    = dr_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule
